// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the serial program loader: the loader FSM state
// encoding, the stream framing constants and a small state-class helper.
// -----------------------------------------------------------------------------
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } loaderState_e;

   // Header is a 16-bit little-endian word count.
   localparam int HDR_BYTES  = 2;
   // Each instruction word arrives as 4 little-endian bytes.
   localparam int WORD_BYTES = 4;

   // States in which a new load request is honoured.
   function automatic logic canStart(input loaderState_e s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Little-endian byte-to-word assembler: a 32-bit shift register that moves
// each new byte in at the top, so after four shifts the first byte sits in
// bits [7:0], plus a modulo-4 byte counter.
//
// Ports
//   clk       in   clock
//   reset     in   synchronous active-high reset (counter only)
//   clear     in   restart the byte counter (wins over shiftEn for the count)
//   shiftEn   in   accept byteIn this cycle
//   byteIn    in   8-bit stream byte
//   nextWord  out  word as it will be after shifting byteIn in (combinational)
//   byteCount out  bytes accepted so far in the current group (0..3)
// -----------------------------------------------------------------------------
module byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        shiftEn,
   input  logic [7:0]  byteIn,
   output logic [31:0] nextWord,
   output logic [1:0]  byteCount
);

   logic [31:0] shiftReg;

   assign nextWord = {byteIn, shiftReg[31:8]};

   // The shift register holds data only and is fully overwritten before use,
   // so it carries no reset.
   always_ff @(posedge clk) begin
      if (shiftEn) begin
         shiftReg <= nextWord;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byteCount <= 2'd0;
      end else if (clear) begin
         byteCount <= 2'd0;
      end else if (shiftEn) begin
         byteCount <= byteCount + 2'd1;
      end
   end

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Receives a program over a valid/ready byte stream (16-bit LE word count,
// then N little-endian 32-bit words), writes each word into instruction
// memory at consecutive word addresses and releases the CPU when done.
//
// Ports
//   clk         in   clock (rising edge)
//   reset       in   synchronous active-high reset
//   start       in   load request, honoured in IDLE/DONE/ERROR
//   byte_in     in   stream byte
//   byte_valid  in   byte_in is valid
//   byte_ready  out  loader accepts a byte this cycle (HDR, DATA)
//   imem_we     out  instruction memory write strobe (WRITE only)
//   imem_addr   out  word address, zero-extended
//   imem_wdata  out  instruction word
//   busy        out  HDR, DATA or WRITE
//   cpu_run     out  DONE; core held in reset otherwise
//   error       out  ERROR (oversize header or byte timeout)
// -----------------------------------------------------------------------------
module program_loader #(
   parameter int IMEM_WORDS   = 64,
   parameter int BYTE_TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        busy,
   output logic        cpu_run,
   output logic        error
);
   import loader_pkg::*;

   localparam int IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
   localparam int TO_W  = $clog2(BYTE_TIMEOUT + 1);

   loaderState_e     state;
   loaderState_e     nextState;
   logic [IDX_W-1:0] wordIdx;
   logic [15:0]      wordCount;
   logic [TO_W-1:0]  idleCount;

   logic        xfer;
   logic        startAccept;
   logic        hdrLast;
   logic        dataLast;
   logic        timedOut;
   logic        lastWord;
   logic        packClear;
   logic [31:0] packNext;
   logic [1:0]  packCount;
   logic [15:0] hdrN;

   // byte_ready is a registered state decode, so this handshake never
   // feeds back combinationally into byte_ready.
   assign xfer        = byte_valid & byte_ready;
   assign startAccept = start & canStart(state);
   assign hdrLast     = (packCount == 2'(HDR_BYTES - 1));
   assign dataLast    = (packCount == 2'(WORD_BYTES - 1));
   // First header byte already sits in the top of the shift register.
   assign hdrN        = packNext[31:16];
   // A transfer on the threshold cycle takes priority over the timeout.
   assign timedOut    = !xfer && (idleCount == TO_W'(BYTE_TIMEOUT - 1));
   assign lastWord    = ((17'(wordIdx) + 17'd1) == 17'(wordCount));
   // Header and data share the packer; realign its count at each boundary.
   assign packClear   = startAccept || ((state == ST_HDR) && xfer && hdrLast);

   byte_packer uPacker (
      .clk       (clk),
      .reset     (reset),
      .clear     (packClear),
      .shiftEn   (xfer),
      .byteIn    (byte_in),
      .nextWord  (packNext),
      .byteCount (packCount)
   );

   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) nextState = ST_HDR;
         end
         ST_HDR: begin
            if (xfer && hdrLast) begin
               if (hdrN == 16'd0)                          nextState = ST_DONE;
               else if (32'(hdrN) > 32'(IMEM_WORDS))       nextState = ST_ERROR;
               else                                        nextState = ST_DATA;
            end else if (timedOut) begin
               nextState = ST_ERROR;
            end
         end
         ST_DATA: begin
            if (xfer && dataLast) nextState = ST_WRITE;
            else if (timedOut)    nextState = ST_ERROR;
         end
         ST_WRITE: begin
            nextState = lastWord ? ST_DONE : ST_DATA;
         end
         default: nextState = ST_IDLE;
      endcase
   end

   // Outputs are registered from nextState so they line up with state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= 32'd0;
         imem_wdata <= 32'd0;
         busy       <= 1'b0;
         cpu_run    <= 1'b0;
         error      <= 1'b0;
         wordIdx    <= '0;
         wordCount  <= 16'd0;
         idleCount  <= '0;
      end else begin
         state      <= nextState;
         byte_ready <= (nextState == ST_HDR) || (nextState == ST_DATA);
         imem_we    <= (nextState == ST_WRITE);
         busy       <= (nextState == ST_HDR) || (nextState == ST_DATA) ||
                       (nextState == ST_WRITE);
         cpu_run    <= (nextState == ST_DONE);
         error      <= (nextState == ST_ERROR);

         if (startAccept) begin
            idleCount <= '0;
         end else if ((state == ST_HDR) || (state == ST_DATA)) begin
            if (xfer) idleCount <= '0;
            else      idleCount <= idleCount + 1'b1;
         end

         if (startAccept) begin
            wordIdx <= '0;
         end else if (state == ST_WRITE) begin
            wordIdx <= wordIdx + 1'b1;
         end

         if (startAccept) begin
            wordCount <= 16'd0;
         end else if ((state == ST_HDR) && xfer && hdrLast) begin
            wordCount <= hdrN;
         end

         // Address and data are captured on entry to WRITE and held after.
         if ((state == ST_DATA) && xfer && dataLast) begin
            imem_addr  <= 32'(wordIdx);
            imem_wdata <= packNext;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Table-driven loads plus hand-written sequences for the header, timeout,
// reset-abort and streaming corners; memory writes checked by a scoreboard.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_program_loader;

   localparam int IMEM_WORDS   = 64;
   localparam int BYTE_TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        busy;
   logic        cpu_run;
   logic        error;

   program_loader #(.IMEM_WORDS(IMEM_WORDS), .BYTE_TIMEOUT(BYTE_TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .cpu_run    (cpu_run),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] n;
      logic [31:0] seed;
      logic        expRun;
      logic        expErr;
   } vec_t;

   wr_t  expQ[$];
   vec_t tab[7];
   int   checks = 0;
   int   failures = 0;
   int   writesSeen = 0;
   int   writesPushed = 0;
   int   gapCycles = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (imem_we) begin
         writesSeen++;
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%h:%h required=none", imem_addr, imem_wdata);
         end else begin
            wr_t e;
            e = expQ.pop_front();
            check("write_addr", imem_addr, e.addr);
            check("write_data", imem_wdata, e.data);
         end
      end
      if (busy && !byte_ready) gapCycles++;
   end

   // Called at #1 after a posedge; returns #1 after the accepting edge
   // with byte_valid still high.
   task automatic sendByte(input logic [7:0] b);
      int n;
      n = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         checks++;
         failures++;
         $display("FAIL byte_accept actual=not_ready required=ready");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic sendWord(input logic [31:0] w);
      for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8]);
   endtask

   task automatic pushWrite(input int idx, input logic [31:0] w);
      wr_t e;
      e.addr = 32'(idx);
      e.data = w;
      expQ.push_back(e);
      writesPushed++;
   endtask

   task automatic startLoad();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL wait_idle actual=busy required=idle");
      end
   endtask

   task automatic idleCycles(input int c);
      byte_valid = 1'b0;
      repeat (c) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] w;

      tab[0] = '{16'd1,    32'h12345678, 1'b1, 1'b0};
      tab[1] = '{16'd0,    32'h00000000, 1'b1, 1'b0};
      tab[2] = '{16'd65,   32'h00000000, 1'b0, 1'b1};
      tab[3] = '{16'd3,    32'hCAFEF00D, 1'b1, 1'b0};
      tab[4] = '{16'h0100, 32'h00000000, 1'b0, 1'b1};
      tab[5] = '{16'd64,   32'h0BADBEEF, 1'b1, 1'b0};
      tab[6] = '{16'd2,    32'h80000000, 1'b1, 1'b0};

      reset = 1'b1;
      start = 1'b0;
      byte_in = 8'h00;
      byte_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cpu_run", 32'(cpu_run), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Known program; a start pulse mid-load must be ignored.
      startLoad();
      check("hdr_busy", 32'(busy), 32'd1);
      check("hdr_ready", 32'(byte_ready), 32'd1);
      sendByte(8'h02); sendByte(8'h00);
      pushWrite(0, 32'hE3A00001);
      pushWrite(1, 32'hE3A01002);
      start = 1'b1;
      sendByte(8'h01); sendByte(8'h00); sendByte(8'hA0); sendByte(8'hE3);
      start = 1'b0;
      sendByte(8'h02); sendByte(8'h10); sendByte(8'hA0); sendByte(8'hE3);
      byte_valid = 1'b0;
      waitIdle();
      check("prog_cpu_run", 32'(cpu_run), 32'd1);
      check("prog_busy", 32'(busy), 32'd0);
      check("prog_error", 32'(error), 32'd0);
      check("prog_pending", 32'(expQ.size()), 32'd0);

      // Table of loads with generated payloads, streamed back to back.
      for (int t = 0; t < 7; t++) begin
         startLoad();
         sendByte(tab[t].n[7:0]);
         sendByte(tab[t].n[15:8]);
         if (tab[t].expRun) begin
            for (int i = 0; i < int'(tab[t].n); i++) begin
               w = tab[t].seed + 32'(i) * 32'h10203041;
               pushWrite(i, w);
               sendWord(w);
            end
         end
         byte_valid = 1'b0;
         waitIdle();
         check($sformatf("tab%0d_cpu_run", t), 32'(cpu_run), 32'(tab[t].expRun));
         check($sformatf("tab%0d_error", t), 32'(error), 32'(tab[t].expErr));
         check($sformatf("tab%0d_ready", t), 32'(byte_ready), 32'd0);
         check($sformatf("tab%0d_pending", t), 32'(expQ.size()), 32'd0);
      end

      // Zero-length header: DONE within two cycles of the second byte.
      startLoad();
      sendByte(8'h00); sendByte(8'h00);
      byte_valid = 1'b0;
      @(posedge clk);
      #1;
      check("n0_cpu_run", 32'(cpu_run), 32'd1);
      check("n0_busy", 32'(busy), 32'd0);

      // Byte timeout in DATA, then a fresh load restarts at address 0.
      startLoad();
      sendByte(8'h01); sendByte(8'h00);
      sendByte(8'h11); sendByte(8'h22);
      idleCycles(BYTE_TIMEOUT - 1);
      check("to_error_early", 32'(error), 32'd0);
      check("to_busy_early", 32'(busy), 32'd1);
      idleCycles(1);
      check("to_error", 32'(error), 32'd1);
      check("to_ready", 32'(byte_ready), 32'd0);
      check("to_busy", 32'(busy), 32'd0);
      startLoad();
      sendByte(8'h01); sendByte(8'h00);
      pushWrite(0, 32'hA5A55A5A);
      sendWord(32'hA5A55A5A);
      byte_valid = 1'b0;
      waitIdle();
      check("to_restart_run", 32'(cpu_run), 32'd1);
      check("to_restart_pending", 32'(expQ.size()), 32'd0);

      // Each byte arrives on the last cycle before the timeout threshold.
      startLoad();
      idleCycles(BYTE_TIMEOUT - 1); sendByte(8'h01);
      idleCycles(BYTE_TIMEOUT - 1); sendByte(8'h00);
      pushWrite(0, 32'h89ABCDEF);
      w = 32'h89ABCDEF;
      for (int k = 0; k < 4; k++) begin
         idleCycles(BYTE_TIMEOUT - 1);
         sendByte(w[8*k +: 8]);
      end
      byte_valid = 1'b0;
      waitIdle();
      check("edge_error", 32'(error), 32'd0);
      check("edge_cpu_run", 32'(cpu_run), 32'd1);
      check("edge_pending", 32'(expQ.size()), 32'd0);

      // Reset after three bytes of word 1 aborts without writing addr 1.
      startLoad();
      sendByte(8'h02); sendByte(8'h00);
      pushWrite(0, 32'h01020304);
      sendWord(32'h01020304);
      sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC);
      byte_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_byte_ready", 32'(byte_ready), 32'd0);
      check("abort_imem_we", 32'(imem_we), 32'd0);
      check("abort_imem_addr", imem_addr, 32'd0);
      check("abort_imem_wdata", imem_wdata, 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cpu_run", 32'(cpu_run), 32'd0);
      check("abort_error", 32'(error), 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_pending", 32'(expQ.size()), 32'd0);
      check("abort_idle_busy", 32'(busy), 32'd0);

      // One ready gap per written word; total writes as expected.
      check("write_count", 32'(writesSeen), 32'(writesPushed));
      check("gap_per_word", 32'(gapCycles), 32'(writesSeen));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
